// File: rtl/adc_emu_pkg.sv
// Shared defaults and state type for the serial ADC emulator.
package adc_emu_pkg;

  localparam int unsigned N_CH       = 8;
  localparam int unsigned DATA_W     = 12;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned LEAD_ZEROS = 4;
  localparam int unsigned ADDR_W     = 3;

  // Rising edge (pre-increment count) on which the address MSB is sampled.
  localparam int unsigned ADDR_FIRST_RISE = 2;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with registered rise/fall pulses; reset level is a parameter.
module sync_edge #(
  parameter logic RstVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       rise_q;
  logic       fall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {2{RstVal}};
      prev_q <= RstVal;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], d_i};
      prev_q <= sync_q[1];
      rise_q <= sync_q[1] & ~prev_q;
      fall_q <= ~sync_q[1] & prev_q;
    end
  end

  assign q_o    = sync_q[1];
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI mode-3 responder emulating an 8-channel 12-bit ADC; address in frame n picks data of n+1.
module adc_spi_responder
  import adc_emu_pkg::*;
#(
  parameter int unsigned N_CH       = adc_emu_pkg::N_CH,
  parameter int unsigned DATA_W     = adc_emu_pkg::DATA_W,
  parameter int unsigned FRAME_BITS = adc_emu_pkg::FRAME_BITS,
  parameter int unsigned LEAD_ZEROS = adc_emu_pkg::LEAD_ZEROS,
  parameter int unsigned ADDR_W     = adc_emu_pkg::ADDR_W
) (
  input  logic                     i_clk,
  input  logic                     reset,
  input  logic                     sclk,
  input  logic                     ss_n,
  input  logic                     mosi,
  input  logic [N_CH*DATA_W-1:0]   i_ch_data,
  output logic                     miso,
  output logic                     miso_oe,
  output logic                     o_frame_done,
  output logic                     o_abort,
  output logic [ADDR_W-1:0]        o_next_ch,
  output logic [15:0]              o_frame_cnt
);

  localparam int unsigned CntW = $clog2(FRAME_BITS);
  localparam logic [CntW-1:0] LastRise = CntW'(FRAME_BITS - 1);
  localparam logic [CntW-1:0] AddrLo   = CntW'(ADDR_FIRST_RISE);
  localparam logic [CntW-1:0] AddrHi   = CntW'(ADDR_FIRST_RISE + ADDR_W - 1);

  logic sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;
  logic sclk_s_unused, ss_s_unused;
  logic [1:0] mosi_edge_unused;

  sync_edge #(.RstVal(1'b1)) u_sync_sclk (
    .clk_i  (i_clk),
    .rst_i  (reset),
    .d_i    (sclk),
    .q_o    (sclk_s_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  sync_edge #(.RstVal(1'b1)) u_sync_ss (
    .clk_i  (i_clk),
    .rst_i  (reset),
    .d_i    (ss_n),
    .q_o    (ss_s_unused),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  sync_edge #(.RstVal(1'b0)) u_sync_mosi (
    .clk_i  (i_clk),
    .rst_i  (reset),
    .d_i    (mosi),
    .q_o    (mosi_s),
    .rise_o (mosi_edge_unused[0]),
    .fall_o (mosi_edge_unused[1])
  );

  logic [DATA_W-1:0] words [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_words
    assign words[k] = i_ch_data[k*DATA_W +: DATA_W];
  end

  state_e                state_q, state_d;
  logic [CntW-1:0]       rise_cnt_q, rise_cnt_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [ADDR_W-1:0]     addr_sh_q, addr_sh_d;
  logic [ADDR_W-1:0]     next_ch_q, next_ch_d;
  logic                  oe_q, oe_d;
  logic                  done_q, done_d;
  logic                  abort_q, abort_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;

  always_comb begin
    state_d     = state_q;
    rise_cnt_d  = rise_cnt_q;
    shreg_d     = shreg_q;
    addr_sh_d   = addr_sh_q;
    next_ch_d   = next_ch_q;
    oe_d        = oe_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;

    // Chip-select edges win over any sclk edge landing in the same cycle.
    if (ss_rise) begin
      state_d    = IDLE;
      oe_d       = 1'b0;
      rise_cnt_d = '0;
      if (state_q == SHIFT && rise_cnt_q != '0) begin
        abort_d = 1'b1;
      end
    end else if (ss_fall) begin
      state_d    = SHIFT;
      rise_cnt_d = '0;
      shreg_d    = {{LEAD_ZEROS{1'b0}}, words[next_ch_q]};
      oe_d       = 1'b1;
    end else if (state_q == SHIFT) begin
      if (sclk_rise) begin
        if (rise_cnt_q == LastRise) begin
          // Reload here so back-to-back frames present their MSB before the next rise.
          rise_cnt_d  = '0;
          next_ch_d   = addr_sh_q;
          shreg_d     = {{LEAD_ZEROS{1'b0}}, words[addr_sh_q]};
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          rise_cnt_d = rise_cnt_q + 1'b1;
          if (rise_cnt_q >= AddrLo && rise_cnt_q <= AddrHi) begin
            addr_sh_d = {addr_sh_q[ADDR_W-2:0], mosi_s};
          end
        end
      end else if (sclk_fall && rise_cnt_q != '0) begin
        shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rise_cnt_q  <= '0;
      shreg_q     <= '0;
      addr_sh_q   <= '0;
      next_ch_q   <= '0;
      oe_q        <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rise_cnt_q  <= rise_cnt_d;
      shreg_q     <= shreg_d;
      addr_sh_q   <= addr_sh_d;
      next_ch_q   <= next_ch_d;
      oe_q        <= oe_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign miso         = oe_q & shreg_q[FRAME_BITS-1];
  assign miso_oe      = oe_q;
  assign o_frame_done = done_q;
  assign o_abort      = abort_q;
  assign o_next_ch    = next_ch_q;
  assign o_frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: 200 MHz system clock, 2 MHz mode-3 SPI master.
`timescale 1ns / 1ps
module tb_adc_spi_responder;

  localparam int HALF = 50;  // half sclk period in i_clk cycles

  logic        i_clk = 1'b0;
  logic        reset;
  logic        sclk;
  logic        ss_n;
  logic        mosi;
  logic [95:0] i_ch_data;
  logic        miso;
  logic        miso_oe;
  logic        o_frame_done;
  logic        o_abort;
  logic [2:0]  o_next_ch;
  logic [15:0] o_frame_cnt;

  logic [11:0] ch_val [8];

  always #2.5 i_clk = ~i_clk;

  for (genvar k = 0; k < 8; k++) begin : g_ch
    assign i_ch_data[k*12 +: 12] = ch_val[k];
  end

  adc_spi_responder dut (
    .i_clk        (i_clk),
    .reset        (reset),
    .sclk         (sclk),
    .ss_n         (ss_n),
    .mosi         (mosi),
    .i_ch_data    (i_ch_data),
    .miso         (miso),
    .miso_oe      (miso_oe),
    .o_frame_done (o_frame_done),
    .o_abort      (o_abort),
    .o_next_ch    (o_next_ch),
    .o_frame_cnt  (o_frame_cnt)
  );

  int   checks = 0;
  int   errors = 0;
  int   done_pulses = 0;
  int   abort_pulses = 0;
  int   long_pulses = 0;
  logic done_prev = 1'b0;
  logic abort_prev = 1'b0;

  always @(negedge i_clk) begin
    if (o_frame_done === 1'b1) done_pulses <= done_pulses + 1;
    if (o_abort === 1'b1) abort_pulses <= abort_pulses + 1;
    if ((o_frame_done === 1'b1 && done_prev) || (o_abort === 1'b1 && abort_prev))
      long_pulses <= long_pulses + 1;
    done_prev  <= (o_frame_done === 1'b1);
    abort_prev <= (o_abort === 1'b1);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Master side of one frame; nbits < 16 stops early with ss_n still low.
  task automatic run_frame(input logic [2:0] addr, input int nbits, input logic deselect,
                           input int chg_at, input logic [11:0] chg_val,
                           output logic [15:0] word);
    word = '0;
    if (ss_n) begin
      ss_n = 1'b0;
      wait_clk(HALF);
    end
    for (int b = 0; b < nbits; b++) begin
      sclk = 1'b0;
      if (b >= 2 && b <= 4) mosi = addr[4-b];
      else mosi = b[0];
      wait_clk(HALF);
      word[15-b] = miso;
      if (b == 8) check("oe_mid_frame", {15'd0, miso_oe}, 16'd1);
      sclk = 1'b1;
      if (chg_at != 0 && b + 1 == chg_at) ch_val[0] = chg_val;
      wait_clk(HALF);
    end
    if (deselect) begin
      ss_n = 1'b1;
      wait_clk(HALF);
    end
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] exp_word;
    logic [2:0]  exp_next;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] w, w1, w2;
    int          d0, a0;
    int          exp_cnt;

    reset = 1'b1;
    sclk  = 1'b1;
    ss_n  = 1'b1;
    mosi  = 1'b0;
    ch_val[0] = 12'hABC; ch_val[1] = 12'h5A5; ch_val[2] = 12'h800; ch_val[3] = 12'h333;
    ch_val[4] = 12'h7FF; ch_val[5] = 12'h123; ch_val[6] = 12'hFFF; ch_val[7] = 12'h001;

    // Each frame returns the channel addressed by the previous frame (ch0 after reset).
    vecs[0] = '{3'd0, 16'h0ABC, 3'd0};
    vecs[1] = '{3'd5, 16'h0ABC, 3'd5};
    vecs[2] = '{3'd7, 16'h0123, 3'd7};
    vecs[3] = '{3'd2, 16'h0001, 3'd2};
    vecs[4] = '{3'd6, 16'h0800, 3'd6};
    vecs[5] = '{3'd4, 16'h0FFF, 3'd4};
    vecs[6] = '{3'd3, 16'h07FF, 3'd3};
    vecs[7] = '{3'd1, 16'h0333, 3'd1};

    wait_clk(5);
    check("rst_miso", {15'd0, miso}, 16'd0);
    check("rst_oe", {15'd0, miso_oe}, 16'd0);
    check("rst_done", {15'd0, o_frame_done}, 16'd0);
    check("rst_abort", {15'd0, o_abort}, 16'd0);
    check("rst_next", {13'd0, o_next_ch}, 16'd0);
    check("rst_cnt", o_frame_cnt, 16'd0);
    reset = 1'b0;
    wait_clk(10);
    exp_cnt = 0;

    for (int i = 0; i < 8; i++) begin
      d0 = done_pulses;
      run_frame(vecs[i].addr, 16, 1'b1, 0, 12'h000, w);
      exp_cnt++;
      check($sformatf("vec%0d_word", i), w, vecs[i].exp_word);
      check($sformatf("vec%0d_next", i), {13'd0, o_next_ch}, {13'd0, vecs[i].exp_next});
      check($sformatf("vec%0d_cnt", i), o_frame_cnt, 16'(exp_cnt));
      check($sformatf("vec%0d_done", i), 16'(done_pulses - d0), 16'd1);
      check($sformatf("vec%0d_oe_off", i), {15'd0, miso_oe}, 16'd0);
    end

    // Continuous frames with ss_n held low.
    run_frame(3'd0, 16, 1'b1, 0, 12'h000, w);
    exp_cnt++;
    check("pre_cont_word", w, 16'h05A5);
    ch_val[0] = 12'h001;
    d0 = done_pulses;
    run_frame(3'd3, 16, 1'b0, 0, 12'h000, w1);
    run_frame(3'd7, 16, 1'b1, 0, 12'h000, w2);
    exp_cnt += 2;
    check("cont_word1", w1, 16'h0001);
    check("cont_word2", w2, 16'h0333);
    check("cont_done", 16'(done_pulses - d0), 16'd2);
    check("cont_next", {13'd0, o_next_ch}, 16'd7);
    check("cont_cnt", o_frame_cnt, 16'(exp_cnt));

    // Abort after 7 rising edges.
    a0 = abort_pulses;
    d0 = done_pulses;
    run_frame(3'd2, 7, 1'b0, 0, 12'h000, w);
    ss_n = 1'b1;
    wait_clk(3);
    check("abort_oe_hold", {15'd0, miso_oe}, 16'd1);
    wait_clk(1);
    check("abort_oe_off", {15'd0, miso_oe}, 16'd0);
    wait_clk(20);
    check("abort_pulse", 16'(abort_pulses - a0), 16'd1);
    check("abort_no_done", 16'(done_pulses - d0), 16'd0);
    check("abort_cnt", o_frame_cnt, 16'(exp_cnt));
    check("abort_next", {13'd0, o_next_ch}, 16'd7);
    run_frame(3'd0, 16, 1'b1, 0, 12'h000, w);
    exp_cnt++;
    check("post_abort_word", w, 16'h0001);
    check("post_abort_next", {13'd0, o_next_ch}, 16'd0);
    check("post_abort_cnt", o_frame_cnt, 16'(exp_cnt));

    // Data snapshot: ch0 changes after rise 8 of the frame reading it.
    ch_val[0] = 12'hFFF;
    run_frame(3'd0, 16, 1'b1, 8, 12'h000, w);
    exp_cnt++;
    check("snap_word", w, 16'h0FFF);
    run_frame(3'd0, 16, 1'b1, 0, 12'h000, w);
    exp_cnt++;
    check("snap_next_word", w, 16'h0000);
    check("clean_no_abort", 16'(abort_pulses - a0), 16'd1);

    // Reset mid-frame after address 6 was captured.
    ch_val[0] = 12'h5C3;
    a0 = abort_pulses;
    d0 = done_pulses;
    run_frame(3'd6, 6, 1'b0, 0, 12'h000, w);
    reset = 1'b1;
    wait_clk(2);
    check("mrst_miso", {15'd0, miso}, 16'd0);
    check("mrst_oe", {15'd0, miso_oe}, 16'd0);
    check("mrst_next", {13'd0, o_next_ch}, 16'd0);
    check("mrst_cnt", o_frame_cnt, 16'd0);
    ss_n = 1'b1;
    sclk = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    exp_cnt = 0;
    wait_clk(10);
    check("mrst_done", {15'd0, o_frame_done}, 16'd0);
    check("mrst_abort", {15'd0, o_abort}, 16'd0);
    run_frame(3'd1, 16, 1'b1, 0, 12'h000, w);
    exp_cnt++;
    check("mrst_word", w, 16'h05C3);
    check("mrst_next_after", {13'd0, o_next_ch}, 16'd1);
    check("mrst_cnt_after", o_frame_cnt, 16'(exp_cnt));
    check("mrst_pulses", 16'(done_pulses - d0), 16'd1);
    check("mrst_no_abort", 16'(abort_pulses - a0), 16'd0);
    check("pulse_width", 16'(long_pulses), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
